mac_result_drain: RTL and testbench
===================================

Name: mac_result_drain

Overview:
- Reader side of the PE accumulator registers in the systolic MAC array.
- Captures one row of N accumulated results in parallel into a shadow buffer, then streams them out one word per handshake on a valid/ready interface.
- Pulses a clear request back to the PE row so the array can start the next accumulation while the drain is still streaming.
- Sits between the array's result registers and the output collector / writeback path.

Parameters:
- WIDTH, 16, bit width of each result word.
- N, 4, number of result words per row (N >= 2).
- IDXW, $clog2(N), width of the word index (derived, not overridable).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clear_n  input  1  synchronous active-low reset.
- load_valid  input  1  row of results is presented on load_data.
- load_ready  output  1  drain can accept a row this cycle.
- load_data  input  N*WIDTH  packed row; word k = load_data[k*WIDTH +: WIDTH].
- pe_clear  output  1  one-cycle pulse requesting the PE row to zero its accumulators.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  current result word.
- out_idx  output  IDXW  index k of the current word.
- out_last  output  1  current word is k = N-1.
- busy  output  1  high while in DRAIN.

Behaviour:
- Clock and reset: single clock clk; reset clear_n is synchronous, active-low.
- Reset values (clear_n = 0 at a rising edge):
  - state = IDLE, index = 0, shadow buffer = 0.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, pe_clear = 0, busy = 0.
  - Reset overrides every other input, including mid-drain; a partially streamed row is discarded with no further output.
- States:
  - IDLE: load_ready = 1, out_valid = 0.
  - DRAIN: out_valid = 1, busy = 1.
- load_ready is combinational: (state == IDLE) || (out_valid && out_ready && out_last). load_ready is never high in DRAIN except on the last-word handshake cycle.
- Load handshake (load_valid && load_ready at an edge):
  - All N words are copied into the shadow buffer.
  - index = 0; state goes to DRAIN.
  - pe_clear = 1 for exactly the next cycle.
  - Latency: the first word appears on out_data one cycle after the load edge.
- Output handshake in DRAIN (out_valid && out_ready at an edge):
  - If index < N-1: index increments and out_data updates to the next word on the following cycle.
  - If index == N-1 and there is no simultaneous load: state goes to IDLE and out_valid = 0 next cycle.
  - If index == N-1 and there is a simultaneous load: the new row is captured, index = 0, state stays DRAIN, and pe_clear pulses. Back-to-back rows stream with no bubble.
- Stall: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. The shadow buffer is never modified during DRAIN except on the last-word reload above.
- out_data, out_idx and out_last are registered, or driven from registered state through a shadow-buffer mux only; they have no combinational path from out_ready or load_data.
- out_last = (index == N-1) while out_valid; otherwise 0.
- Words are emitted in order k = 0 .. N-1 with no reordering, truncation or sign change; each value is a WIDTH-bit pass-through.
- load_valid while load_ready = 0 is ignored. The producer holds the row until it is accepted; there is no internal queue beyond the single shadow buffer.
- pe_clear never asserts for two consecutive cycles unless two loads are accepted on consecutive edges. That is impossible for N >= 2.

Decomposition:
- Shared package mac_pkg holds:
  - typedef enum logic {IDLE, DRAIN} drain_state_t;
  - default WIDTH/N constants shared with the PE array.
- The shadow buffer is N instances of reg_def, each with WIDTH = WIDTH and enable = load handshake.
  - reg_def's clear is async active-high, so the shadow clear is driven from a registered ~clear_n pulse, or the buffer is coded inline.
  - Either choice is acceptable provided the reset behaviour above holds.
- No other sub-module.

Test Plan:
- Reset: hold clear_n = 0 for 3 cycles with load_valid = 1 -> out_valid = 0, pe_clear = 0, load_ready = 1 after release, no capture during reset.
- Basic drain (N = 4, WIDTH = 16): load words 0x0011, 0x0022, 0x0033, 0x0044 with out_ready = 1.
  - Expect pe_clear high 1 cycle after the load.
  - Expect out_data = 0x0011, 0x0022, 0x0033, 0x0044 on 4 consecutive cycles, out_idx = 0..3, out_last only on 0x0044.
  - Then out_valid = 0.
- Backpressure: same row with out_ready low for 3 cycles at idx 1 -> out_data held at 0x0022 and out_idx = 1 throughout; load_ready = 0; a load_valid pulse with 0xFFFF words is ignored.
- Back-to-back: present row B (0xB000..0xB003) with load_valid held during the drain of row A.
  - Expect row B to be accepted on A's last handshake.
  - Expect 0xB000 to follow 0x0044 on the next cycle with no bubble, and pe_clear to pulse once per row.
- Reset mid-drain: assert clear_n = 0 after idx 1 is emitted -> next cycle out_valid = 0, busy = 0, state IDLE.
  - A subsequent load of 0x00AA.. streams from idx 0 with no stale words.
- Full-width values: load 0xFFFF, 0x8000, 0x0000, 0x7FFF -> emitted bit-exact, in order.

Source files
------------

// File: rtl/mac_pkg.sv
// Types and default sizes shared between the MAC array and its result drain.
package mac_pkg;

  localparam int unsigned MAC_WIDTH = 16;
  localparam int unsigned MAC_N     = 4;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

endpackage

// File: rtl/mac_result_drain.sv
// Captures one row of PE accumulator results into a shadow buffer and streams them out
// one word per valid/ready handshake, pulsing pe_clear so the array can restart early.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH,
  parameter int unsigned N     = MAC_N,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [N*WIDTH-1:0]   load_data,
  output logic                 pe_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

  drain_state_t r_state, w_state_d;
  logic [IDXW-1:0]  r_idx, w_idx_d;
  logic [WIDTH-1:0] r_shadow [N];
  logic             r_pe_clear;

  logic w_out_hs;
  logic w_at_last;
  logic w_load_hs;

  assign w_at_last  = (r_idx == LastIdx);
  assign w_out_hs   = out_valid && out_ready;
  // A new row may land on the same edge the final word of the current row leaves.
  assign load_ready = (r_state == IDLE) || (w_out_hs && w_at_last);
  assign w_load_hs  = load_valid && load_ready;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_load_hs) begin
          w_state_d = DRAIN;
          w_idx_d   = '0;
        end
      end
      DRAIN: begin
        if (w_out_hs) begin
          if (!w_at_last) begin
            w_idx_d = r_idx + IDXW'(1);
          end else if (w_load_hs) begin
            w_idx_d = '0;
          end else begin
            w_state_d = IDLE;
            w_idx_d   = '0;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
        w_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pe_clear <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_pe_clear <= w_load_hs;
    end
  end

  // Shadow buffer only changes on an accepted load, so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (w_load_hs) begin
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= load_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid = (r_state == DRAIN);
  assign busy      = (r_state == DRAIN);
  assign pe_clear  = r_pe_clear;
  assign out_data  = r_shadow[r_idx];
  assign out_idx   = r_idx;
  assign out_last  = out_valid && w_at_last;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed-vector bench for mac_result_drain (N = 4, WIDTH = 16).
module tb_mac_result_drain;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 4;

  logic              clk;
  logic              clear_n;
  logic              load_valid;
  logic              load_ready;
  logic [N*WIDTH-1:0] load_data;
  logic              pe_clear;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;

  mac_result_drain #(
    .WIDTH(WIDTH),
    .N    (N)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .pe_clear  (pe_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks the current word on the falling edge, then moves past the next rising edge.
  task automatic expect_word(input string grp, input int k, input logic [15:0] d,
                             input logic pe, input logic lr);
    @(negedge clk);
    check($sformatf("%s.valid%0d", grp, k), 32'(out_valid), 32'd1);
    check($sformatf("%s.busy%0d", grp, k), 32'(busy), 32'd1);
    check($sformatf("%s.data%0d", grp, k), 32'(out_data), 32'(d));
    check($sformatf("%s.idx%0d", grp, k), 32'(out_idx), 32'(k));
    check($sformatf("%s.last%0d", grp, k), 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
    check($sformatf("%s.pe%0d", grp, k), 32'(pe_clear), 32'(pe));
    check($sformatf("%s.lrdy%0d", grp, k), 32'(load_ready), 32'(lr));
    next_cycle();
  endtask

  task automatic expect_idle(input string grp);
    @(negedge clk);
    check({grp, ".valid"}, 32'(out_valid), 32'd0);
    check({grp, ".busy"}, 32'(busy), 32'd0);
    check({grp, ".last"}, 32'(out_last), 32'd0);
    check({grp, ".pe"}, 32'(pe_clear), 32'd0);
    check({grp, ".lrdy"}, 32'(load_ready), 32'd1);
  endtask

  // Presents a row for one cycle from IDLE.
  task automatic load_row(input string grp, input logic [63:0] row);
    load_data  = row;
    load_valid = 1'b1;
    @(negedge clk);
    check({grp, ".load_rdy"}, 32'(load_ready), 32'd1);
    next_cycle();
    load_valid = 1'b0;
  endtask

  logic [63:0] row_a;
  logic [63:0] row_b;
  logic [63:0] row_c;
  logic [63:0] row_f;

  initial begin
    row_a = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    row_b = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    row_c = {16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA};
    row_f = {16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF};

    clear_n    = 1'b0;
    load_valid = 1'b1;
    load_data  = {4{16'h5A5A}};
    out_ready  = 1'b1;
    next_cycle();

    // Reset held with a row offered: nothing is captured
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst.valid%0d", i), 32'(out_valid), 32'd0);
      check($sformatf("rst.pe%0d", i), 32'(pe_clear), 32'd0);
      next_cycle();
    end
    clear_n    = 1'b1;
    load_valid = 1'b0;
    expect_idle("rst_rel");
    check("rst_rel.data", 32'(out_data), 32'd0);
    check("rst_rel.idx", 32'(out_idx), 32'd0);
    next_cycle();

    // Basic drain
    out_ready = 1'b1;
    load_row("basic", row_a);
    expect_word("basic", 0, 16'h0011, 1'b1, 1'b0);
    expect_word("basic", 1, 16'h0022, 1'b0, 1'b0);
    expect_word("basic", 2, 16'h0033, 1'b0, 1'b0);
    expect_word("basic", 3, 16'h0044, 1'b0, 1'b1);
    expect_idle("basic_end");
    next_cycle();

    // Backpressure at idx 1, with an ignored load attempt
    load_row("bp", row_a);
    expect_word("bp", 0, 16'h0011, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = (i == 1);
      load_data  = {4{16'hFFFF}};
      @(negedge clk);
      check($sformatf("bp.hold_data%0d", i), 32'(out_data), 32'h0022);
      check($sformatf("bp.hold_idx%0d", i), 32'(out_idx), 32'd1);
      check($sformatf("bp.hold_lrdy%0d", i), 32'(load_ready), 32'd0);
      check($sformatf("bp.hold_valid%0d", i), 32'(out_valid), 32'd1);
      next_cycle();
    end
    load_valid = 1'b0;
    out_ready  = 1'b1;
    expect_word("bp", 1, 16'h0022, 1'b0, 1'b0);
    expect_word("bp", 2, 16'h0033, 1'b0, 1'b0);
    expect_word("bp", 3, 16'h0044, 1'b0, 1'b1);
    expect_idle("bp_end");
    next_cycle();

    // Back-to-back: row B waits, is taken on A's last handshake, no bubble
    load_row("b2b", row_a);
    load_data  = row_b;
    load_valid = 1'b1;
    expect_word("b2b_a", 0, 16'h0011, 1'b1, 1'b0);
    expect_word("b2b_a", 1, 16'h0022, 1'b0, 1'b0);
    expect_word("b2b_a", 2, 16'h0033, 1'b0, 1'b0);
    expect_word("b2b_a", 3, 16'h0044, 1'b0, 1'b1);
    load_valid = 1'b0;
    expect_word("b2b_b", 0, 16'hB000, 1'b1, 1'b0);
    expect_word("b2b_b", 1, 16'hB001, 1'b0, 1'b0);
    expect_word("b2b_b", 2, 16'hB002, 1'b0, 1'b0);
    expect_word("b2b_b", 3, 16'hB003, 1'b0, 1'b1);
    expect_idle("b2b_end");
    next_cycle();

    // Reset mid-drain discards the rest of the row
    load_row("mid", row_c);
    expect_word("mid", 0, 16'h00AA, 1'b1, 1'b0);
    expect_word("mid", 1, 16'h00BB, 1'b0, 1'b0);
    clear_n = 1'b0;
    next_cycle();
    clear_n = 1'b1;
    expect_idle("mid_rst");
    check("mid_rst.data", 32'(out_data), 32'd0);
    check("mid_rst.idx", 32'(out_idx), 32'd0);
    next_cycle();
    load_row("mid_re", row_c);
    expect_word("mid_re", 0, 16'h00AA, 1'b1, 1'b0);
    expect_word("mid_re", 1, 16'h00BB, 1'b0, 1'b0);
    expect_word("mid_re", 2, 16'h00CC, 1'b0, 1'b0);
    expect_word("mid_re", 3, 16'h00DD, 1'b0, 1'b1);
    expect_idle("mid_re_end");
    next_cycle();

    // Full-width values pass through bit-exact
    load_row("full", row_f);
    expect_word("full", 0, 16'hFFFF, 1'b1, 1'b0);
    expect_word("full", 1, 16'h8000, 1'b0, 1'b0);
    expect_word("full", 2, 16'h0000, 1'b0, 1'b0);
    expect_word("full", 3, 16'h7FFF, 1'b0, 1'b1);
    expect_idle("full_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
